// File: rtl/moesi_pkg.sv
// Shared encodings for the snoop path: MOESI line states, snoop request
// types and the responder FSM states.
package moesi_pkg;

    typedef enum logic [2:0] {
        ST_I = 3'b000,
        ST_M = 3'b001,
        ST_O = 3'b010,
        ST_E = 3'b100,
        ST_S = 3'b101
    } moesi_e;

    typedef enum logic [1:0] {
        SNP_NOOP    = 2'b00,
        SNP_READ    = 2'b01,
        SNP_WRITE   = 2'b10,
        SNP_UPGRADE = 2'b11
    } snp_type_e;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_LOOKUP = 2'd1,
        FSM_DATA   = 2'd2,
        FSM_RESP   = 2'd3
    } snp_fsm_e;

    // A dirty line (M or O) is the one whose data must be supplied on a snoop.
    function automatic logic is_dirty(input moesi_e st);
        logic dirty_s;
        case (st)
            ST_M:    dirty_s = 1'b1;
            ST_O:    dirty_s = 1'b1;
            default: dirty_s = 1'b0;
        endcase
        return dirty_s;
    endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// Coherence-bus snoop channel: request handshake plus the single response.
interface snoop_responder_if #(
    parameter int ADDR_W = 64,
    parameter int LINE_W = 512
);
    logic              snp_valid;
    logic              snp_ready;
    logic [1:0]        snp_type;
    logic [ADDR_W-1:0] snp_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_hit;
    logic              resp_shared;
    logic              resp_data_valid;
    logic [LINE_W-1:0] resp_data;

    modport master (
        output snp_valid, snp_type, snp_addr, resp_ready,
        input  snp_ready, resp_valid, resp_hit, resp_shared, resp_data_valid, resp_data
    );

    modport slave (
        input  snp_valid, snp_type, snp_addr, resp_ready,
        output snp_ready, resp_valid, resp_hit, resp_shared, resp_data_valid, resp_data
    );
endinterface

// File: rtl/snoop_handler.sv
// Combinational MOESI snoop decision: hit detection, next line state and
// whether this cache must supply the line data.
module snoop_handler
    import moesi_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  snp_type_e         snp_type,
    input  logic [ADDR_W-1:0] snp_addr,
    input  logic              tag_match,
    input  logic              line_valid,
    input  moesi_e            cur_state,
    output logic              hit,
    output moesi_e            new_state,
    output logic              provide_data,
    output logic              state_change
);

    // The outcome depends only on type and state; the address is carried for context.
    logic unused_addr_s;
    assign unused_addr_s = ^snp_addr;

    assign hit          = tag_match & line_valid;
    assign state_change = hit & (new_state != cur_state);

    // MOESI transition table for a snoop that hits this cache.
    always_comb begin
        new_state    = cur_state;
        provide_data = 1'b0;
        if (hit) begin
            case (snp_type)
                SNP_READ: begin
                    provide_data = is_dirty(cur_state);
                    case (cur_state)
                        ST_M:    new_state = ST_O;
                        ST_E:    new_state = ST_S;
                        default: new_state = cur_state;
                    endcase
                end
                SNP_WRITE, SNP_UPGRADE: begin
                    provide_data = is_dirty(cur_state);
                    new_state    = ST_I;
                end
                default: begin
                    new_state    = cur_state;
                    provide_data = 1'b0;
                end
            endcase
        end else begin
            new_state    = cur_state;
            provide_data = 1'b0;
        end
    end

endmodule

// File: rtl/snoop_responder.sv
// Snoop front end: accepts one snoop at a time, looks up tag/state, applies
// the MOESI decision, optionally fetches the line and returns one response.
module snoop_responder
    import moesi_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 6,
    parameter int LINE_W   = 512,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic               clk,
    input  logic               rst,
    snoop_responder_if.slave   bus,
    output logic               tag_rd_en,
    output logic [INDEX_W-1:0] tag_rd_idx,
    input  logic [TAG_W-1:0]   tag_rd_tag,
    input  logic [2:0]         tag_rd_state,
    output logic               st_wr_en,
    output logic [INDEX_W-1:0] st_wr_idx,
    output logic [2:0]         st_wr_state,
    output logic               data_rd_en,
    output logic [INDEX_W-1:0] data_rd_idx,
    input  logic [LINE_W-1:0]  data_rd_data
);

    snp_fsm_e          state_r;
    snp_fsm_e          state_nxt_s;
    snp_type_e         type_r;
    logic [ADDR_W-1:0] addr_r;
    logic              handshake_s;
    logic              tag_match_s;
    logic              line_valid_s;
    logic              hit_s;
    logic              provide_data_s;
    logic              state_change_s;
    moesi_e            new_state_s;
    logic              resp_hit_r;
    logic              resp_shared_r;
    logic              resp_dv_r;
    logic [LINE_W-1:0] resp_data_r;

    // snp_ready is gated by rst so nothing is accepted while reset is held.
    assign bus.snp_ready = (state_r == FSM_IDLE) & ~rst;
    assign handshake_s   = bus.snp_valid & bus.snp_ready;

    assign tag_rd_en    = handshake_s;
    assign tag_rd_idx   = bus.snp_addr[OFFSET_W +: INDEX_W];
    assign tag_match_s  = (tag_rd_tag == addr_r[ADDR_W-1 -: TAG_W]);
    assign line_valid_s = (tag_rd_state != ST_I);

    assign st_wr_idx   = addr_r[OFFSET_W +: INDEX_W];
    assign st_wr_state = new_state_s;
    assign data_rd_idx = addr_r[OFFSET_W +: INDEX_W];

    assign bus.resp_valid      = (state_r == FSM_RESP);
    assign bus.resp_hit        = resp_hit_r;
    assign bus.resp_shared     = resp_shared_r;
    assign bus.resp_data_valid = resp_dv_r;
    assign bus.resp_data       = resp_data_r;

    snoop_handler #(
        .ADDR_W (ADDR_W)
    ) u_handler (
        .snp_type     (type_r),
        .snp_addr     (addr_r),
        .tag_match    (tag_match_s),
        .line_valid   (line_valid_s),
        .cur_state    (moesi_e'(tag_rd_state)),
        .hit          (hit_s),
        .new_state    (new_state_s),
        .provide_data (provide_data_s),
        .state_change (state_change_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FSM_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and the single-cycle array strobes of the LOOKUP cycle.
    always_comb begin
        state_nxt_s = state_r;
        st_wr_en    = 1'b0;
        data_rd_en  = 1'b0;
        case (state_r)
            FSM_IDLE: begin
                if (handshake_s) begin
                    state_nxt_s = FSM_LOOKUP;
                end else begin
                    state_nxt_s = FSM_IDLE;
                end
            end
            FSM_LOOKUP: begin
                st_wr_en = state_change_s;
                if (provide_data_s) begin
                    data_rd_en  = 1'b1;
                    state_nxt_s = FSM_DATA;
                end else begin
                    state_nxt_s = FSM_RESP;
                end
            end
            FSM_DATA: begin
                state_nxt_s = FSM_RESP;
            end
            FSM_RESP: begin
                if (bus.resp_ready) begin
                    state_nxt_s = FSM_IDLE;
                end else begin
                    state_nxt_s = FSM_RESP;
                end
            end
            default: begin
                state_nxt_s = FSM_IDLE;
            end
        endcase
    end

    // Request capture and response registers; held untouched through RESP stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_r        <= SNP_NOOP;
            addr_r        <= {ADDR_W{1'b0}};
            resp_hit_r    <= 1'b0;
            resp_shared_r <= 1'b0;
            resp_dv_r     <= 1'b0;
            resp_data_r   <= {LINE_W{1'b0}};
        end else begin
            case (state_r)
                FSM_IDLE: begin
                    if (handshake_s) begin
                        type_r <= snp_type_e'(bus.snp_type);
                        addr_r <= bus.snp_addr;
                    end
                end
                FSM_LOOKUP: begin
                    resp_hit_r    <= hit_s;
                    resp_shared_r <= hit_s & (new_state_s != ST_I);
                    resp_dv_r     <= provide_data_s;
                    if (!provide_data_s) begin
                        resp_data_r <= {LINE_W{1'b0}};
                    end
                end
                FSM_DATA: begin
                    resp_data_r <= data_rd_data;
                end
                default: begin
                    resp_data_r <= resp_data_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_responder.sv
// Directed and randomized bench for snoop_responder with an array model and
// a rule-level MOESI reference.
module tb_snoop_responder;
    localparam int ADDR_W = 64;
    localparam int LINE_W = 512;
    localparam int TAG_W  = 52;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snoop_responder_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus_if ();

    logic              tag_rd_en, st_wr_en, data_rd_en;
    logic [5:0]        tag_rd_idx, st_wr_idx, data_rd_idx;
    logic [TAG_W-1:0]  tag_rd_tag;
    logic [2:0]        tag_rd_state, st_wr_state;
    logic [LINE_W-1:0] data_rd_data;

    snoop_responder dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_if),
        .tag_rd_en    (tag_rd_en),
        .tag_rd_idx   (tag_rd_idx),
        .tag_rd_tag   (tag_rd_tag),
        .tag_rd_state (tag_rd_state),
        .st_wr_en     (st_wr_en),
        .st_wr_idx    (st_wr_idx),
        .st_wr_state  (st_wr_state),
        .data_rd_en   (data_rd_en),
        .data_rd_idx  (data_rd_idx),
        .data_rd_data (data_rd_data)
    );

    // Array image, written only by the stimulus process.
    logic [TAG_W-1:0]  tag_mem  [64];
    logic [2:0]        state_mem[64];
    logic [LINE_W-1:0] data_mem [64];
    int wr_cnt = 0;
    int drd_cnt = 0;
    int n_cmp = 0;
    int n_err = 0;

    // Array timing model: read data one cycle after the strobe.
    always @(posedge clk) begin
        if (tag_rd_en) begin
            tag_rd_tag   <= tag_mem[tag_rd_idx];
            tag_rd_state <= state_mem[tag_rd_idx];
        end
        if (data_rd_en) data_rd_data <= data_mem[data_rd_idx];
        if (st_wr_en) wr_cnt <= wr_cnt + 1;
        if (data_rd_en) drd_cnt <= drd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rules: what the snoop must do to a line, from the MOESI table.
    function automatic void model(input logic [1:0] t, input logic [2:0] st, input bit match,
                                  output bit hit, output bit shared, output bit dat,
                                  output logic [2:0] nst);
        bit dirty;
        hit   = match && (st != 3'b000);
        dirty = (st == 3'b001) || (st == 3'b010);
        nst   = st;
        dat   = 1'b0;
        if (hit && t == 2'b01) begin
            dat = dirty;
            if (st == 3'b001) nst = 3'b010;
            if (st == 3'b100) nst = 3'b101;
        end
        if (hit && (t == 2'b10 || t == 2'b11)) begin
            dat = dirty;
            nst = 3'b000;
        end
        shared = hit && (nst != 3'b000);
    endfunction

    function automatic logic [63:0] mk_addr(input int idx, input bit match);
        logic [TAG_W-1:0] tg;
        logic [5:0] ix;
        logic [5:0] off;
        tg  = tag_mem[idx];
        if (!match) tg = tg ^ 52'h8_0000_0000_0011;
        ix  = 6'(idx);
        off = 6'($urandom);
        return {tg, ix, off};
    endfunction

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic preload(input int idx, input logic [2:0] st);
        logic [63:0] r;
        r = {$urandom, $urandom};
        tag_mem[idx]   = r[TAG_W-1:0];
        state_mem[idx] = st;
        data_mem[idx]  = rnd_line();
    endtask

    // One complete snoop, entered and left at a falling edge. With chain set,
    // the next request (nt/na) is raised while the response is still pending.
    task automatic do_snoop(input logic [1:0] t, input logic [63:0] a, input int stall,
                            input bit chain, input logic [1:0] nt, input logic [63:0] na);
        int idx, w0, d0, lat;
        bit match, e_hit, e_sh, e_dat, e_wr, seen;
        logic [2:0] e_st;
        logic [LINE_W-1:0] e_data;
        idx   = int'(a[11:6]);
        match = (a[63:12] == tag_mem[idx]);
        model(t, state_mem[idx], match, e_hit, e_sh, e_dat, e_st);
        e_wr   = e_hit && (e_st != state_mem[idx]);
        e_data = e_dat ? data_mem[idx] : {LINE_W{1'b0}};
        w0 = wr_cnt;
        d0 = drd_cnt;
        bus_if.resp_ready = (stall == 0);
        bus_if.snp_valid  = 1'b1;
        bus_if.snp_type   = t;
        bus_if.snp_addr   = a;
        #1;
        chk("snp_ready_idle", bus_if.snp_ready, 64'd1);
        chk("tag_rd_en", tag_rd_en, 64'd1);
        chk("tag_rd_idx", tag_rd_idx, 64'(idx));
        @(negedge clk);
        bus_if.snp_valid = 1'b0;
        chk("st_wr_en", st_wr_en, 64'(e_wr));
        if (e_wr) begin
            chk("st_wr_state", st_wr_state, 64'(e_st));
            chk("st_wr_idx", st_wr_idx, 64'(idx));
        end
        chk("data_rd_en", data_rd_en, 64'(e_dat));
        chk("snp_ready_busy", bus_if.snp_ready, 64'd0);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            @(negedge clk);
            lat++;
            if (bus_if.resp_valid) seen = 1'b1;
        end
        chk("resp_seen", 64'(seen), 64'd1);
        chk("resp_latency", 64'(lat), e_dat ? 64'd3 : 64'd2);
        chk("resp_hit", bus_if.resp_hit, 64'(e_hit));
        chk("resp_shared", bus_if.resp_shared, 64'(e_sh));
        chk("resp_data_valid", bus_if.resp_data_valid, 64'(e_dat));
        chk_w("resp_data", bus_if.resp_data, e_data);
        if (chain) begin
            bus_if.snp_valid = 1'b1;
            bus_if.snp_type  = nt;
            bus_if.snp_addr  = na;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", bus_if.resp_valid, 64'd1);
            chk("stall_hit", bus_if.resp_hit, 64'(e_hit));
            chk_w("stall_data", bus_if.resp_data, e_data);
            chk("stall_snp_ready", bus_if.snp_ready, 64'd0);
            chk("stall_tag_rd_en", tag_rd_en, 64'd0);
        end
        bus_if.resp_ready = 1'b1;
        @(negedge clk);
        chk("resp_done", bus_if.resp_valid, 64'd0);
        chk("snp_ready_back", bus_if.snp_ready, 64'd1);
        if (chain) chk("chain_accept", tag_rd_en, 64'd1);
        chk("wr_count", 64'(wr_cnt - w0), 64'(e_wr));
        chk("data_rd_count", 64'(drd_cnt - d0), 64'(e_dat));
        state_mem[idx] = e_st;
    endtask

    initial begin
        logic [63:0] a, a2;
        int w0;
        logic [2:0] st_pick [5];
        st_pick = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bus_if.snp_valid  = 1'b0;
        bus_if.snp_type   = 2'b00;
        bus_if.snp_addr   = 64'd0;
        bus_if.resp_ready = 1'b1;
        for (int i = 0; i < 64; i++) preload(i, 3'b000);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_snp_ready", bus_if.snp_ready, 64'd0);
        chk("rst_resp_valid", bus_if.resp_valid, 64'd0);
        chk("rst_resp_hit", bus_if.resp_hit, 64'd0);
        chk("rst_st_wr_en", st_wr_en, 64'd0);
        rst = 1'b0;

        // READ hit M, READ hit E, UPGRADE hit S, WRITE hit O
        preload(1, 3'b001); do_snoop(2'b01, mk_addr(1, 1'b1), 0, 1'b0, 2'b00, 64'd0);
        preload(2, 3'b100); do_snoop(2'b01, mk_addr(2, 1'b1), 0, 1'b0, 2'b00, 64'd0);
        preload(3, 3'b101); do_snoop(2'b11, mk_addr(3, 1'b1), 0, 1'b0, 2'b00, 64'd0);
        preload(4, 3'b010); do_snoop(2'b10, mk_addr(4, 1'b1), 0, 1'b0, 2'b00, 64'd0);
        // Misses: tag mismatch on M, matching tag on I; no-op on a valid line
        preload(6, 3'b001); do_snoop(2'b10, mk_addr(6, 1'b0), 0, 1'b0, 2'b00, 64'd0);
        preload(7, 3'b000); do_snoop(2'b01, mk_addr(7, 1'b1), 0, 1'b0, 2'b00, 64'd0);
        preload(8, 3'b001); do_snoop(2'b00, mk_addr(8, 1'b1), 0, 1'b0, 2'b00, 64'd0);

        // Response stall of 5 cycles with the next snoop already waiting
        preload(9, 3'b001);
        preload(10, 3'b100);
        a2 = mk_addr(10, 1'b1);
        do_snoop(2'b01, mk_addr(9, 1'b1), 5, 1'b1, 2'b10, a2);
        do_snoop(2'b10, a2, 0, 1'b0, 2'b00, 64'd0);

        // Reset during DATA on a READ of an O line
        preload(5, 3'b010);
        a = mk_addr(5, 1'b1);
        w0 = wr_cnt;
        bus_if.snp_valid = 1'b1;
        bus_if.snp_type  = 2'b01;
        bus_if.snp_addr  = a;
        @(negedge clk);
        bus_if.snp_valid = 1'b0;
        chk("rstmid_data_rd_en", data_rd_en, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        bus_if.snp_valid = 1'b1;
        #1;
        chk("rstmid_resp_valid", bus_if.resp_valid, 64'd0);
        chk("rstmid_resp_dv", bus_if.resp_data_valid, 64'd0);
        chk_w("rstmid_resp_data", bus_if.resp_data, {LINE_W{1'b0}});
        chk("rstmid_snp_ready", bus_if.snp_ready, 64'd0);
        chk("rstmid_tag_rd_en", tag_rd_en, 64'd0);
        chk("rstmid_data_rd_en0", data_rd_en, 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_held", bus_if.resp_valid, 64'd0);
        bus_if.snp_valid = 1'b0;
        rst = 1'b0;
        chk("rstmid_no_write", 64'(wr_cnt - w0), 64'd0);
        do_snoop(2'b01, a, 0, 1'b0, 2'b00, 64'd0);

        // Randomized snoops over a few sets, states persisting between snoops
        for (int n = 0; n < 40; n++) begin
            int idx;
            idx = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) preload(idx, st_pick[$urandom_range(0, 4)]);
            a = mk_addr(idx, $urandom_range(0, 3) != 0);
            do_snoop(2'($urandom_range(0, 3)), a, int'($urandom_range(0, 2)), 1'b0, 2'b00, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
